stat_display_sequencer: RTL

Rotates the fitness tracker's four statistics onto the shared 16-bit display bus feeding the seven-segment display controller. It sits between the step tracker and the display controller and schedules which statistic owns the display, holding each for a fixed dwell time. It also generates the `is_miles` format flag and a load strobe on every slot change. It supports freeze (hold) and enable gating.

---
 rtl/stat_display_sequencer_pkg.sv | 9 +
 rtl/stat_display_sequencer_if.sv | 22 ++
 rtl/stat_display_sequencer_dwell_timer.sv | 22 ++
 rtl/stat_display_sequencer.sv | 67 ++++++
 4 files changed

// File: rtl/stat_display_sequencer_pkg.sv
// fitbit_pkg: shared statistic encoding, FSM states and display clamp helper
package fitbit_pkg;
    typedef enum logic [1:0] {STAT_STEPS, STAT_DIST, STAT_OVER32, STAT_HIGH} stat_t;
    typedef enum logic [2:0] {IDLE, SHOW_STEPS, SHOW_DIST, SHOW_OVER32, SHOW_HIGH} state_t;
    localparam logic [15:0] FITBIT_DISPLAY_MAX = 16'd9999;
    function automatic logic [15:0] clamp16(input logic [15:0] v, input logic [15:0] m);
        return (v > m) ? m : v;
    endfunction
endpackage

// File: rtl/stat_display_sequencer_if.sv
// stat_display_sequencer_if: statistic inputs, control and display-bus outputs
interface stat_display_sequencer_if;
    import fitbit_pkg::*;
    logic        enable;
    logic        hold;
    logic [15:0] step_count;
    logic [15:0] distance;
    logic [15:0] over32_secs;
    logic [15:0] high_act_secs;
    logic [15:0] display;
    logic        is_miles;
    stat_t       stat_sel;
    logic        load;
    modport master (
        output enable, hold, step_count, distance, over32_secs, high_act_secs,
        input  display, is_miles, stat_sel, load
    );
    modport slave (
        input  enable, hold, step_count, distance, over32_secs, high_act_secs,
        output display, is_miles, stat_sel, load
    );
endinterface

// File: rtl/stat_display_sequencer_dwell_timer.sv
// dwell_timer: counts 0..DWELL_CYCLES-1, flags terminal count, freezable and clearable
module dwell_timer #(
    parameter int unsigned DWELL_CYCLES = 200_000_000
) (
    input  logic CLK,
    input  logic reset,
    input  logic clear,
    input  logic freeze,
    output logic expire
);
    localparam int W = $clog2(DWELL_CYCLES);
    localparam logic [W-1:0] TC = W'(DWELL_CYCLES - 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        expire = (cnt_q == TC);
        cnt_d  = clear ? '0 : freeze ? cnt_q : expire ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge CLK) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/stat_display_sequencer.sv
// stat_display_sequencer: rotates four fitness statistics onto the display bus
// with a fixed dwell per slot, hold/enable gating and a per-slot load strobe.
module stat_display_sequencer
    import fitbit_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 200_000_000,
    parameter logic [15:0] MAX_DISPLAY  = FITBIT_DISPLAY_MAX
) (
    input logic CLK,
    input logic reset,
    stat_display_sequencer_if.slave bus
);
    state_t      state_q, state_d;
    logic [15:0] display_q, display_d;
    logic        is_miles_q, is_miles_d;
    stat_t       stat_sel_q, stat_sel_d;
    logic        load_q, load_d;
    logic        expire;
    logic [15:0] raw;

    dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_timer (
        .CLK    (CLK),
        .reset  (reset),
        .clear  (!bus.enable || state_q == IDLE),
        .freeze (bus.hold),
        .expire (expire)
    );

    // Outputs are derived from the next state so they change on the same edge as the slot
    always_comb begin
        state_d = state_q;
        if (!bus.enable)                  state_d = IDLE;
        else if (state_q == IDLE)         state_d = SHOW_STEPS;
        else if (expire && !bus.hold)     state_d = (state_q == SHOW_HIGH) ? SHOW_STEPS : state_t'(state_q + 3'd1);
        raw = (state_d == SHOW_STEPS)  ? bus.step_count  :
              (state_d == SHOW_DIST)   ? bus.distance    :
              (state_d == SHOW_OVER32) ? bus.over32_secs :
              (state_d == SHOW_HIGH)   ? bus.high_act_secs : 16'd0;
        display_d  = clamp16(raw, MAX_DISPLAY);
        is_miles_d = (state_d == SHOW_DIST);
        stat_sel_d = (state_d == SHOW_DIST)   ? STAT_DIST   :
                     (state_d == SHOW_OVER32) ? STAT_OVER32 :
                     (state_d == SHOW_HIGH)   ? STAT_HIGH   : STAT_STEPS;
        load_d     = (state_d != IDLE) && (state_d != state_q);
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q    <= IDLE;
            display_q  <= '0;
            is_miles_q <= 1'b0;
            stat_sel_q <= STAT_STEPS;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            display_q  <= display_d;
            is_miles_q <= is_miles_d;
            stat_sel_q <= stat_sel_d;
            load_q     <= load_d;
        end
    end

    assign bus.display  = display_q;
    assign bus.is_miles = is_miles_q;
    assign bus.stat_sel = stat_sel_q;
    assign bus.load     = load_q;
endmodule
